// File: rtl/adr_brk_ctl.sv
// Address-break controller: compares each started reference's VMA against the
// loaded break address/conditions and sequences page-fail request, ack and inhibit.
module adr_brk_ctl #(
  parameter int ADR_W = 23,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_cond,
  input  logic [ADR_W-1:0] brk_adr_in,
  input  logic [3:0]       cond_in,
  input  logic [ADR_W-1:0] vma,
  input  logic             ref_valid,
  input  logic             ref_fetch,
  input  logic             ref_read,
  input  logic             ref_write,
  input  logic             ref_user,
  input  logic             brk_inh,
  input  logic             pf_ack,
  input  logic             inst_done,
  input  logic             clr_count,
  output logic             brk_req,
  output logic             brk_busy,
  output logic [ADR_W-1:0] brk_adr_q,
  output logic [3:0]       cond_q,
  output logic [ADR_W-1:0] brk_vma,
  output logic [CNT_W-1:0] brk_count
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    PENDING  = 2'd2,
    INHIBIT  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic match;
  logic type_ok;
  logic mode_ok;
  logic trigger;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // cond bits are {fetch, read, write, user}, MSB first
  assign match   = (vma == brk_adr_q);
  assign type_ok = (cond_q[3] & ref_fetch) | (cond_q[2] & ref_read) | (cond_q[1] & ref_write);
  assign mode_ok = ~cond_q[0] | ref_user;
  assign trigger = (state_q == ARMED) & ref_valid & match & type_ok & mode_ok & ~brk_inh;

  assign brk_busy = (state_q == PENDING) || (state_q == INHIBIT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DISARMED: begin
        if (load_cond) state_d = (|cond_in[3:1]) ? ARMED : DISARMED;
      end
      ARMED: begin
        if (trigger)        state_d = PENDING;
        else if (load_cond) state_d = (|cond_in[3:1]) ? ARMED : DISARMED;
      end
      PENDING: begin
        if (pf_ack) state_d = INHIBIT;
      end
      INHIBIT: begin
        if (inst_done) state_d = (|cond_q[3:1]) ? ARMED : DISARMED;
      end
      default: state_d = DISARMED;
    endcase
  end

  // control stage: state and registered request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DISARMED;
      brk_req <= 1'b0;
    end else begin
      state_q <= state_d;
      brk_req <= (state_d == PENDING);
    end
  end

  // break registers; trigger uses the pre-load address/conditions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk_adr_q <= '0;
      cond_q    <= '0;
      brk_vma   <= '0;
      brk_count <= '0;
    end else begin
      if (load_cond) begin
        brk_adr_q <= brk_adr_in;
        cond_q    <= cond_in;
      end
      if (trigger) brk_vma <= vma;
      if (clr_count)    brk_count <= '0;
      else if (trigger) brk_count <= sat_inc(brk_count);
    end
  end

endmodule

// File: tb/tb_adr_brk_ctl.sv
// Bench for adr_brk_ctl: directed vector table, reset-mid-break sequence and
// random traffic checked against a rule-level reference model.
module tb_adr_brk_ctl;

  localparam int ADR_W = 23;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_cond;
  logic [ADR_W-1:0] brk_adr_in;
  logic [3:0]       cond_in;
  logic [ADR_W-1:0] vma;
  logic             ref_valid, ref_fetch, ref_read, ref_write, ref_user;
  logic             brk_inh, pf_ack, inst_done, clr_count;
  logic             brk_req, brk_busy;
  logic [ADR_W-1:0] brk_adr_q, brk_vma;
  logic [3:0]       cond_q;
  logic [CNT_W-1:0] brk_count;

  adr_brk_ctl #(.ADR_W(ADR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .load_cond(load_cond), .brk_adr_in(brk_adr_in),
    .cond_in(cond_in), .vma(vma), .ref_valid(ref_valid), .ref_fetch(ref_fetch),
    .ref_read(ref_read), .ref_write(ref_write), .ref_user(ref_user),
    .brk_inh(brk_inh), .pf_ack(pf_ack), .inst_done(inst_done),
    .clr_count(clr_count), .brk_req(brk_req), .brk_busy(brk_busy),
    .brk_adr_q(brk_adr_q), .cond_q(cond_q), .brk_vma(brk_vma),
    .brk_count(brk_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: whether a break is armed, requested, or waiting for
  // instruction end, plus the architected registers.
  bit               m_armed, m_waiting_ack, m_waiting_done;
  logic [ADR_W-1:0] m_adr, m_vma;
  logic [3:0]       m_cond;
  int               m_count;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  task automatic model_reset();
    m_armed = 0; m_waiting_ack = 0; m_waiting_done = 0;
    m_adr = '0; m_cond = '0; m_vma = '0; m_count = 0;
  endtask

  task automatic model_step();
    bit hit, kind_ok, user_ok;
    kind_ok = (m_cond[3] && ref_fetch) || (m_cond[2] && ref_read) || (m_cond[1] && ref_write);
    user_ok = !m_cond[0] || ref_user;
    hit = m_armed && ref_valid && (vma == m_adr) && kind_ok && user_ok && !brk_inh;
    if (clr_count) m_count = 0;
    else if (hit) m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
    if (hit) begin
      m_vma = vma;
      m_armed = 0;
      m_waiting_ack = 1;
    end else if (m_waiting_ack) begin
      if (pf_ack) begin m_waiting_ack = 0; m_waiting_done = 1; end
    end else if (m_waiting_done) begin
      if (inst_done) begin m_waiting_done = 0; m_armed = (m_cond[3:1] != 0); end
    end else if (load_cond) begin
      m_armed = (cond_in[3:1] != 0);
    end
    if (load_cond) begin
      m_adr = brk_adr_in;
      m_cond = cond_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("brk_req",   32'(brk_req),   32'(m_waiting_ack));
    chk("brk_busy",  32'(brk_busy),  32'(m_waiting_ack | m_waiting_done));
    chk("brk_adr_q", 32'(brk_adr_q), 32'(m_adr));
    chk("cond_q",    32'(cond_q),    32'(m_cond));
    chk("brk_vma",   32'(brk_vma),   32'(m_vma));
    chk("brk_count", 32'(brk_count), 32'(m_count));
  endtask

  typedef struct {
    logic             load;
    logic [ADR_W-1:0] adr;
    logic [3:0]       cond;
    logic [ADR_W-1:0] va;
    logic             valid;
    logic [2:0]       typ;
    logic             usr, inh, ack, done, clr;
    logic             e_req;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic [ADR_W-1:0] a, input logic [3:0] c,
                              input logic [ADR_W-1:0] v, input logic vl, input logic [2:0] t,
                              input logic u, input logic ih, input logic ak, input logic dn,
                              input logic cl, input logic er, input logic [CNT_W-1:0] ec);
    vec_t r;
    r.load = ld; r.adr = a; r.cond = c; r.va = v; r.valid = vl; r.typ = t;
    r.usr = u; r.inh = ih; r.ack = ak; r.done = dn; r.clr = cl; r.e_req = er; r.e_cnt = ec;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    load_cond = v.load; brk_adr_in = v.adr; cond_in = v.cond; vma = v.va;
    ref_valid = v.valid; {ref_fetch, ref_read, ref_write} = v.typ;
    ref_user = v.usr; brk_inh = v.inh; pf_ack = v.ack; inst_done = v.done;
    clr_count = v.clr;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v);
    tick();
    chk($sformatf("vec%0d_req", idx), 32'(brk_req), 32'(v.e_req));
    chk($sformatf("vec%0d_cnt", idx), 32'(brk_count), 32'(v.e_cnt));
  endtask

  localparam logic [2:0] F = 3'b100, R = 3'b010, W = 3'b001;
  localparam logic [ADR_W-1:0] A123 = 23'h000123, A010 = 23'h000010, A020 = 23'h000020;

  vec_t vt[27];
  logic [ADR_W-1:0] pool[4];

  initial begin
    //            ld adr   cond     vma   vl typ u ih ak dn cl  req cnt
    vt[0]  = mk(1, A123, 4'b1000, 0,    0, 0, 0, 0, 0, 0, 0,  0, 0);
    vt[1]  = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 1, 1, 0,  0, 0);
    vt[2]  = mk(0, 0,    4'b0000, A123, 1, F, 0, 0, 0, 0, 0,  1, 1);
    vt[3]  = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 0, 0, 0,  1, 1);
    vt[4]  = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 1, 0, 0,  0, 1);
    vt[5]  = mk(0, 0,    4'b0000, A123, 1, F, 0, 0, 0, 0, 0,  0, 1);
    vt[6]  = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 0, 1, 0,  0, 1);
    vt[7]  = mk(1, A123, 4'b0010, 0,    0, 0, 0, 0, 0, 0, 0,  0, 1);
    vt[8]  = mk(0, 0,    4'b0000, A123, 1, R, 0, 0, 0, 0, 0,  0, 1);
    vt[9]  = mk(1, A123, 4'b1001, 0,    0, 0, 0, 0, 0, 0, 0,  0, 1);
    vt[10] = mk(0, 0,    4'b0000, A123, 1, F, 0, 0, 0, 0, 0,  0, 1);
    vt[11] = mk(0, 0,    4'b0000, A123, 1, F, 1, 0, 0, 0, 0,  1, 2);
    vt[12] = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 1, 0, 0,  0, 2);
    vt[13] = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 0, 1, 0,  0, 2);
    vt[14] = mk(0, 0,    4'b0000, A123, 1, F, 1, 1, 0, 0, 0,  0, 2);
    vt[15] = mk(1, A010, 4'b1000, 0,    0, 0, 0, 0, 0, 0, 0,  0, 2);
    vt[16] = mk(1, A020, 4'b1000, A010, 1, F, 0, 0, 0, 0, 0,  1, 3);
    vt[17] = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 1, 0, 0,  0, 3);
    vt[18] = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 0, 1, 0,  0, 3);
    vt[19] = mk(0, 0,    4'b0000, A020, 1, F, 0, 0, 0, 0, 0,  1, 3);
    vt[20] = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 1, 0, 0,  0, 3);
    vt[21] = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 0, 1, 0,  0, 3);
    vt[22] = mk(0, 0,    4'b0000, A020, 1, F, 0, 0, 0, 0, 1,  1, 0);
    vt[23] = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 1, 0, 0,  0, 0);
    vt[24] = mk(0, 0,    4'b0000, 0,    0, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[25] = mk(1, A020, 4'b0000, 0,    0, 0, 0, 0, 0, 0, 0,  0, 0);
    vt[26] = mk(0, 0,    4'b0000, A020, 1, F, 0, 0, 0, 0, 0,  0, 0);

    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   32'(brk_req),   32'd0);
    chk("rst_busy",  32'(brk_busy),  32'd0);
    chk("rst_adr",   32'(brk_adr_q), 32'd0);
    chk("rst_cond",  32'(cond_q),    32'd0);
    chk("rst_vma",   32'(brk_vma),   32'd0);
    chk("rst_count", 32'(brk_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) apply(vt[i], i);
    chk("sim_load_adr", 32'(brk_adr_q), 32'(A020));

    // reset while a break request is outstanding
    apply(mk(1, 23'h55, 4'b0100, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0), 100);
    apply(mk(0, 0,      4'b0000, 23'h55, 1, R, 0, 0, 0, 0, 0, 1, 1), 101);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_req",   32'(brk_req),   32'd0);
    chk("mid_rst_busy",  32'(brk_busy),  32'd0);
    chk("mid_rst_adr",   32'(brk_adr_q), 32'd0);
    chk("mid_rst_cond",  32'(cond_q),    32'd0);
    chk("mid_rst_vma",   32'(brk_vma),   32'd0);
    chk("mid_rst_count", 32'(brk_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mk(0, 0, 4'b0000, 0, 1, 3'b111, 1, 0, 0, 0, 0, 0, 0), 102);

    // random traffic over a small address pool so matches are frequent
    pool[0] = A010; pool[1] = A020; pool[2] = A123; pool[3] = 23'h7FFFFF;
    for (int c = 0; c < 600; c++) begin
      load_cond  = ($urandom_range(0, 9) == 0);
      brk_adr_in = pool[$urandom_range(0, 3)];
      cond_in    = 4'($urandom);
      vma        = ($urandom_range(0, 7) == 0) ? 23'($urandom) : pool[$urandom_range(0, 3)];
      ref_valid  = ($urandom_range(0, 1) == 1);
      {ref_fetch, ref_read, ref_write} = 3'($urandom);
      ref_user   = 1'($urandom);
      brk_inh    = ($urandom_range(0, 7) == 0);
      pf_ack     = ($urandom_range(0, 3) == 0);
      inst_done  = ($urandom_range(0, 3) == 0);
      clr_count  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adr_brk_ctl.md
# adr_brk_ctl

Address-break controller sitting directly downstream of the VMA board. It holds the address-break address and condition bits loaded by DATAO APR and compares each started memory reference's VMA[13:35] against them. On a qualifying match it raises a page-fail request, waits for acknowledge, then inhibits further breaks until the current instruction completes. It also keeps a saturating break counter for diagnostic readback.

## Interface
- ADR_W, 23: address width compared (VMA bits 13:35, bit 13 = MSB)
- CNT_W, 16: break counter width
- clk  in  1  EBOX clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- load_cond  in  1  DATAO APR strobe: load brk_adr_in and cond_in
- brk_adr_in  in  ADR_W  new break address (EDP.AD[13:35])
- cond_in  in  4  {fetch, read, write, user} enables (EDP.AD[9:12])
- vma  in  ADR_W  current VMA[13:35]
- ref_valid  in  1  memory reference starts this cycle
- ref_fetch, ref_read, ref_write  in  1 each  reference type, qualified by ref_valid
- ref_user  in  1  reference is in user mode
- brk_inh  in  1  ADR BRK INH PC flag; suppresses triggering
- pf_ack  in  1  page-fail logic accepted the break
- inst_done  in  1  instruction completion (NICOND)
- clr_count  in  1  synchronous clear of break counter
- brk_req  out  1  address-break page-fail request
- brk_busy  out  1  state is PENDING or INHIBIT
- brk_adr_q  out  ADR_W  loaded break address
- cond_q  out  4  loaded condition bits
- brk_vma  out  ADR_W  VMA captured at the triggering reference
- brk_count  out  CNT_W  number of breaks taken, saturating

## Operation
- States: DISARMED, ARMED, PENDING, INHIBIT. Reset → DISARMED.
- match = (vma == brk_adr_q); combinational.
- type_ok = (cond_q.fetch & ref_fetch) | (cond_q.read & ref_read) | (cond_q.write & ref_write).
- mode_ok = ~cond_q.user | ref_user.
- trigger = ARMED & ref_valid & match & type_ok & mode_ok & ~brk_inh.
- load_cond: brk_adr_q ← brk_adr_in; cond_q ← cond_in (all states).
  - From DISARMED or ARMED: go to ARMED if cond_in[fetch,read,write] ≠ 0, else DISARMED.
  - From PENDING or INHIBIT: registers update and state is unchanged.
- ARMED & trigger → PENDING. The same edge captures brk_vma ← vma and increments brk_count; brk_count stays at all-ones once reached.
- PENDING: brk_req = 1. pf_ack → INHIBIT.
- INHIBIT: inst_done → ARMED if cond_q type bits ≠ 0, else DISARMED.
- inst_done outside INHIBIT is ignored.
- clr_count zeroes brk_count. If clr_count and a trigger occur on the same edge, clear wins and the result is 0.
- Simultaneous load_cond and a trigger: the trigger is evaluated against the old brk_adr_q/cond_q, and the new values load on the same edge.
- pf_ack is ignored outside PENDING.

## Timing
- Reset values: brk_req 0, brk_busy 0, brk_adr_q 0, cond_q 0, brk_vma 0, brk_count 0, state DISARMED.
- Trigger latency: reference in cycle N → brk_req = 1 from the edge ending N, visible in N+1.
- brk_req is a registered output. It stays high until the edge on which pf_ack is sampled, then falls on that edge.
- INHIBIT → ARMED on the edge sampling inst_done. A matching reference in the following cycle may trigger.
- brk_adr_q, cond_q, brk_vma and brk_count are registered. They change only on the edges defined above.
- An asynchronous reset during PENDING drops brk_req immediately and returns to DISARMED.

## Test plan
- Arm and fetch-match: load_cond with brk_adr_in=23'h000123, cond_in=4'b1000; ref_valid+ref_fetch with vma=23'h000123 in cycle 5 → brk_req=1 in cycle 6, brk_vma=23'h000123, brk_count=1. pf_ack in cycle 9 → brk_req=0 in cycle 10. inst_done in cycle 12 → ARMED in cycle 13.
- Qualifier misses, each with vma equal to brk_adr_q:
  - cond_in=4'b0010 (write only) with a read reference → no brk_req.
  - cond_in=4'b1001 (user-only fetch) with a fetch at ref_user=0 → no brk_req.
  - brk_inh=1 with an otherwise qualifying reference → no brk_req.
- Inhibit window: after ack and before inst_done, apply a matching reference → no new brk_req and brk_count unchanged.
- Simultaneous load and trigger: ARMED at 23'h000010; in one cycle apply load_cond with 23'h000020 and a reference at vma=23'h000010 → brk_req=1 and brk_adr_q=23'h000020 next cycle.
- Saturation and clear: with CNT_W=2, take 4 breaks → brk_count=3. Assert clr_count together with a 5th trigger → brk_count=0.
- Reset mid-break: assert reset while brk_req=1 → brk_req=0 immediately, all outputs at reset values. A matching reference after reset release → no brk_req.
